// File: rtl/inv_shift_rows_serial.sv
// Byte-serial AES (Inv)ShiftRows: 16-byte blocks land in a ping-pong buffer and
// are read back in permuted order, one byte per cycle on each side.
module inv_shift_rows_serial #(
  parameter int INVERSE = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_last,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic       out_last,
  output logic       err_framing
);

  logic [7:0] bank0 [16];
  logic [7:0] bank1 [16];
  logic [3:0] wr_cnt;
  logic [3:0] rd_cnt;
  logic       wr_sel;
  logic       rd_sel;
  logic [1:0] full;
  logic [1:0] full_nxt;
  logic       run;
  logic       in_fire;
  logic       out_fire;
  logic       wr_done;
  logic       rd_done;
  logic [3:0] src_idx;

  // Output position k = {c, r}; the source column is c -/+ r, wrapping mod 4.
  function automatic logic [3:0] perm(input logic [3:0] k);
    logic [1:0] r;
    logic [1:0] c;
    logic [1:0] sc;
    r  = k[1:0];
    c  = k[3:2];
    sc = (INVERSE != 0) ? (c - r) : (c + r);
    return {sc, r};
  endfunction

  // run keeps in_ready low during reset even though the full flags read empty.
  assign in_ready  = run & ~full[wr_sel];
  assign out_valid = full[rd_sel];
  assign out_last  = out_valid & (rd_cnt == 4'd15);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign wr_done   = (wr_cnt == 4'd15);
  assign rd_done   = (rd_cnt == 4'd15);
  assign src_idx   = perm(rd_cnt);
  assign out_data  = rd_sel ? bank1[src_idx] : bank0[src_idx];

  always_comb begin
    full_nxt = full;
    if (in_fire && wr_done) full_nxt[wr_sel] = 1'b1;
    if (out_fire && rd_done) full_nxt[rd_sel] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run         <= 1'b0;
      wr_cnt      <= 4'd0;
      rd_cnt      <= 4'd0;
      wr_sel      <= 1'b0;
      rd_sel      <= 1'b0;
      full        <= 2'b00;
      err_framing <= 1'b0;
    end else begin
      run         <= 1'b1;
      full        <= full_nxt;
      err_framing <= in_fire & (in_last != wr_done);
      if (in_fire) begin
        wr_cnt <= wr_cnt + 4'd1;
        if (wr_done) wr_sel <= ~wr_sel;
      end
      if (out_fire) begin
        rd_cnt <= rd_cnt + 4'd1;
        if (rd_done) rd_sel <= ~rd_sel;
      end
    end
  end

  // Bank storage carries no reset; the full flags decide what is meaningful.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (wr_sel) bank1[wr_cnt] <= in_data;
      else        bank0[wr_cnt] <= in_data;
    end
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Bench for inv_shift_rows_serial: directed scenarios with random bytes, checked
// against a block-level ShiftRows model, plus a forward/inverse loopback chain.
module tb_inv_shift_rows_serial;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'd0;
  logic       in_last = 1'b0;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       out_last;
  logic       err_framing;

  logic       c_in_valid = 1'b0;
  logic       c_in_ready;
  logic [7:0] c_in_data = 8'd0;
  logic       c_in_last = 1'b0;
  logic       m_valid;
  logic       m_ready;
  logic [7:0] m_data;
  logic       m_last;
  logic       fwd_err;
  logic       c_out_valid;
  logic       c_out_ready = 1'b1;
  logic [7:0] c_out_data;
  logic       c_out_last;
  logic       inv_err;

  always #5 clk = ~clk;

  inv_shift_rows_serial #(.INVERSE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid),
    .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .err_framing(err_framing));

  inv_shift_rows_serial #(.INVERSE(0)) u_fwd (
    .clk(clk), .rst_n(rst_n), .in_valid(c_in_valid), .in_ready(c_in_ready),
    .in_data(c_in_data), .in_last(c_in_last), .out_valid(m_valid),
    .out_ready(m_ready), .out_data(m_data), .out_last(m_last),
    .err_framing(fwd_err));

  inv_shift_rows_serial #(.INVERSE(1)) u_inv (
    .clk(clk), .rst_n(rst_n), .in_valid(m_valid), .in_ready(m_ready),
    .in_data(m_data), .in_last(m_last), .out_valid(c_out_valid),
    .out_ready(c_out_ready), .out_data(c_out_data), .out_last(c_out_last),
    .err_framing(inv_err));

  int vectors = 0;
  int miscompares = 0;

  // Reference model state
  logic [7:0] inq[$];
  logic [7:0] expq[$];
  logic [7:0] got[$];
  int blocks = 0;
  int out_idx = 0;
  int accepted = 0;
  int emitted = 0;
  int errs = 0;
  bit err_exp = 1'b0;
  bit capture = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // AES state is column-major: byte k sits at row k%4, column k/4.
  task automatic model_block();
    for (int k = 0; k < 16; k++) begin
      int r;
      int c;
      r = k % 4;
      c = k / 4;
      expq.push_back(inq[r + 4 * ((c - r + 4) % 4)]);
    end
    inq.delete();
    blocks++;
  endtask

  task automatic model_reset();
    inq.delete();
    expq.delete();
    blocks = 0;
    out_idx = 0;
    err_exp = 1'b0;
  endtask

  task automatic cycle(input bit iv, input logic [7:0] id, input bit il, input bit ordy);
    @(negedge clk);
    in_valid = iv;
    in_data = id;
    in_last = il;
    out_ready = ordy;
    #1;
    chk("in_ready", 32'(in_ready), 32'(blocks < 2));
    chk("out_valid", 32'(out_valid), 32'(blocks > 0));
    chk("err_framing", 32'(err_framing), 32'(err_exp));
    chk("out_last", 32'(out_last), 32'(blocks > 0 && out_idx == 15));
    if (out_valid && expq.size() > 0) chk("out_data", 32'(out_data), 32'(expq[0]));
    if (err_framing) errs++;
    err_exp = 1'b0;
    if (iv && in_ready) begin
      accepted++;
      err_exp = (il != (inq.size() == 15));
      inq.push_back(id);
      if (inq.size() == 16) model_block();
    end
    if (ordy && out_valid) begin
      emitted++;
      if (capture) got.push_back(out_data);
      if (expq.size() > 0) void'(expq.pop_front());
      out_idx++;
      if (out_idx == 16) begin
        out_idx = 0;
        blocks--;
      end
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_last", 32'(out_last), 32'd0);
    chk("rst_err", 32'(err_framing), 32'd0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic feed(input int n, input bit ordy);
    for (int i = 0; i < n; i++) cycle(1'b1, 8'($urandom), inq.size() == 15, ordy);
  endtask

  logic [7:0] tbl [16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                           8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  logic [7:0] c_src [48];

  initial begin
    int a0;
    int e0;
    int sent;
    int rcvd;

    do_reset();

    // Counting block 0x00..0x0F through the inverse permutation
    capture = 1'b1;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'(i), i == 15, 1'b1);
    repeat (18) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    capture = 1'b0;
    chk("blk0_count", 32'(got.size()), 32'd16);
    for (int i = 0; i < 16 && i < got.size(); i++) chk("blk0_byte", 32'(got[i]), 32'(tbl[i]));

    // Both banks fill while the sink stalls
    a0 = accepted;
    feed(48, 1'b0);
    chk("stall_accepted", 32'(accepted - a0), 32'd32);
    repeat (36) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Back-to-back blocks at full rate
    a0 = accepted;
    feed(64, 1'b1);
    chk("stream_accepted", 32'(accepted - a0), 32'd64);
    repeat (20) cycle(1'b0, 8'h00, 1'b0, 1'b1);

    // Misplaced in_last: early on byte 7, missing on byte 15
    e0 = errs;
    for (int i = 0; i < 16; i++) cycle(1'b1, 8'($urandom), i == 7, 1'b1);
    repeat (20) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("framing_pulses", 32'(errs - e0), 32'd2);

    // Reset with one block mid-drain and another mid-fill
    feed(16, 1'b0);
    feed(4, 1'b0);
    a0 = accepted;
    e0 = emitted;
    feed(5, 1'b1);
    chk("pre_rst_in", 32'(accepted - a0), 32'd5);
    chk("pre_rst_out", 32'(emitted - e0), 32'd5);
    do_reset();
    e0 = emitted;
    feed(16, 1'b1);
    repeat (20) cycle(1'b0, 8'h00, 1'b0, 1'b1);
    chk("post_rst_out", 32'(emitted - e0), 32'd16);
    in_valid = 1'b0;
    out_ready = 1'b0;

    // Forward then inverse must reproduce the input stream
    sent = 0;
    rcvd = 0;
    for (int cyc = 0; cyc < 800 && rcvd < 48; cyc++) begin
      @(negedge clk);
      c_in_valid = (sent < 48) && ($urandom_range(0, 3) != 0);
      c_in_data = 8'($urandom);
      c_in_last = (sent % 16 == 15);
      #1;
      if (c_in_valid && c_in_ready) begin
        c_src[sent] = c_in_data;
        sent++;
      end
      if (c_out_valid) begin
        if (rcvd < sent) chk("chain_data", 32'(c_out_data), 32'(c_src[rcvd]));
        chk("chain_last", 32'(c_out_last), 32'(rcvd % 16 == 15));
        chk("chain_err", 32'(fwd_err | inv_err), 32'd0);
        rcvd++;
      end
    end
    c_in_valid = 1'b0;
    chk("chain_count", 32'(rcvd), 32'd48);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/inv_shift_rows_serial.md
INV_SHIFT_ROWS_SERIAL -- requirements
Module: inv_shift_rows_serial

Interface
REQ-001 SHALL provide parameter INVERSE, default 1; 1 = AES InvShiftRows permutation, 0 = forward ShiftRows permutation, used for loopback test.
REQ-002 SHALL have port clk  input  1  sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port in_valid  input  1  input byte present.
REQ-005 SHALL have port in_ready  output  1  block can accept input byte.
REQ-006 SHALL have port in_data  input  8  state byte, stream order.
REQ-007 SHALL have port in_last  input  1  sender marks byte 15 of a block.
REQ-008 SHALL have port out_valid  output  1  output byte present.
REQ-009 SHALL have port out_ready  input  1  sink can accept output byte.
REQ-010 SHALL have port out_data  output  8  permuted state byte.
REQ-011 SHALL have port out_last  output  1  high with byte 15 of each output block.
REQ-012 SHALL have port err_framing  output  1  one-cycle pulse on in_last mismatch.

Function
REQ-013 SHALL number block bytes k = 0..15 in stream order, with row r = k mod 4 and column c = k / 4 (column-major AES state).
REQ-014 SHALL, for INVERSE=1, emit out[r,c] = in[r,(c-r) mod 4], giving source order 0,13,10,7,4,1,14,11,8,5,2,15,12,9,6,3.
REQ-015 SHALL, for INVERSE=0, emit out[r,c] = in[r,(c+r) mod 4], giving source order 0,5,10,15,4,9,14,3,8,13,2,7,12,1,6,11.
REQ-016 SHALL transfer a byte on either side only on a cycle where valid and ready are both high.
REQ-017 SHALL buffer data in two 16-byte banks operated ping-pong, each with a full flag.
REQ-018 SHALL write incoming bytes into the write bank at index wr_cnt (4 bits).
REQ-019 SHALL, on the 16th accepted byte, set that bank's full flag, toggle the write-bank select, and wrap wr_cnt to 0.
REQ-020 SHALL drive in_ready = NOT full[write bank]; in_ready is combinational from registered flags only, with no dependence on out_ready.
REQ-021 SHALL drive out_valid = full[read bank].
REQ-022 SHALL drive out_data = read bank[perm(rd_cnt)], where perm is the source order from REQ-014 or REQ-015.
REQ-023 SHALL drive out_last = out_valid AND (rd_cnt == 15).
REQ-024 SHALL, on each output transfer, increment rd_cnt; on the 16th transfer it SHALL clear the bank's full flag, toggle the read-bank select, and wrap rd_cnt to 0.
REQ-025 SHALL have a latency of one cycle: out_valid rises on the cycle after byte 15 of a block is accepted.
REQ-026 SHALL sustain one byte per cycle on both sides when out_ready is held high.
REQ-027 SHALL allow the write side to fill one bank while the read side drains the other in the same cycle.
REQ-028 SHALL handle the buffer-full boundary: when both banks are full, in_ready = 0.
REQ-029 SHALL, when a bank frees in a cycle, raise in_ready on the following cycle and never combinationally in the same cycle.
REQ-030 SHALL pulse err_framing for one cycle if, on an accepted byte, in_last differs from (wr_cnt == 15).
REQ-031 SHALL continue byte counting by wr_cnt after a framing error; blocks are never truncated or padded.
REQ-032 SHALL hold out_data and out_last stable while out_valid=1 and out_ready=0.
REQ-033 SHALL not change outputs in response to in_valid, in_data or out_ready when no transfer occurs.

Reset
REQ-034 SHALL, while rst_n=0, clear wr_cnt, rd_cnt, both bank selects and both full flags to 0, and hold in_ready=0, out_valid=0, out_last=0, err_framing=0.
REQ-035 SHALL leave bank data registers unreset.
REQ-036 SHALL, on reset assertion mid-block, discard all partially written and partially read blocks.
REQ-037 SHALL drive in_ready=1 on the first clock after rst_n deasserts.

Verification
REQ-038 SHALL cover: INVERSE=1, in_data 0x00..0x0F with in_last on 0x0F, out_ready=1 -> outputs 00,0D,0A,07,04,01,0E,0B,08,05,02,0F,0C,09,06,03; out_last on 03; first out_valid one cycle after 0x0F accepted.
REQ-039 SHALL cover: out_ready=0 while 48 bytes are offered -> exactly 32 accepted and in_ready=0 after the 32nd; releasing out_ready then drains 32 correctly permuted bytes and in_ready returns to 1 the cycle after the first bank empties.
REQ-040 SHALL cover: continuous back-to-back blocks with out_ready=1 -> 100% throughput, no in_ready drop after the first block, and output ordering correct across the bank toggle.
REQ-041 SHALL cover: in_last asserted on byte 7 and omitted on byte 15 -> two err_framing pulses, and the output block is still a full 16 correctly permuted bytes.
REQ-042 SHALL cover: rst_n pulsed low after 9 bytes accepted and 5 bytes emitted -> out_valid=0 immediately; the next 16 input bytes produce one clean block starting from output index 0.
REQ-043 SHALL cover: an INVERSE=0 instance chained into an INVERSE=1 instance with random data -> the output stream equals the input stream byte-for-byte.
